rd_burst_ctrl: RTL and testbench

Parametrised read controller for the line cache, replacing the single-word read path. It accepts burst read requests of 1..MAX_BURST words, wrapping within the cache line with the critical word first. It resolves hit/miss against the directory, arbitrates line conflicts with the write controller, and drives allocation and fetch. It returns data through a credit-controlled response FIFO, so downstream backpressure never drops data.

---
 rtl/rd_burst_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rd_burst_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rd_burst_ctrl                                                     |
// | Burst read controller for the line cache: critical-word-first wrapping    |
// | bursts, directory hit/miss, write-conflict arbitration, line allocation    |
// | and fetch, credit-controlled response FIFO.                                |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module rd_burst_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LIST_DEPTH = 4,
   parameter int LIST_WIDTH = 32,
   parameter int MAX_BURST  = 8,
   parameter int FIFO_DEPTH = 4,
   localparam int c_tw = $clog2(LIST_DEPTH),
   localparam int c_ow = $clog2(LIST_WIDTH),
   localparam int c_lw = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [c_lw-1:0]         req_len,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_last,
   output logic                    dir_req,
   output logic [1:0]              dir_cmd,
   output logic [ADDR_WIDTH-1:0]   dir_index,
   input  logic [2:0]              dir_status,
   input  logic [c_tw-1:0]         dir_tag,
   input  logic [ADDR_WIDTH-1:0]   dir_victim,
   input  logic                    alloc_busy,
   output logic [c_tw-1:0]         dir_upd_tag,
   output logic [2:0]              rd_status,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [c_tw-1:0]         rd_tag,
   input  logic [2:0]              wr_status,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [c_tw-1:0]         wr_tag,
   output logic                    fetch_req,
   input  logic                    fetch_gnt,
   input  logic                    fetch_done,
   output logic [1:0]              fetch_cmd,
   output logic [c_tw-1:0]         fetch_tag,
   output logic [ADDR_WIDTH-1:0]   fetch_addr,
   output logic [ADDR_WIDTH-1:0]   fetch_victim,
   output logic                    mem_ren,
   input  logic                    mem_rready,
   output logic [c_tw+c_ow-1:0]    mem_raddr,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_rdata_valid,
   output logic [15:0]             miss_cnt
);

   localparam int c_boff = $clog2(DATA_WIDTH / 8);
   localparam int c_loff = c_boff + c_ow;
   localparam int c_pw   = $clog2(FIFO_DEPTH);
   localparam int c_cw   = c_pw + 1;
   localparam logic [c_cw:0] c_credit = (c_cw + 1)'(FIFO_DEPTH);
   localparam logic [c_ow-1:0] c_last_off = c_ow'(LIST_WIDTH - 1);

   localparam logic [2:0] c_s_idle       = 3'd0;
   localparam logic [2:0] c_s_check      = 3'd1;
   localparam logic [2:0] c_s_wait_conf  = 3'd2;
   localparam logic [2:0] c_s_allocate   = 3'd3;
   localparam logic [2:0] c_s_fetch_req  = 3'd4;
   localparam logic [2:0] c_s_wait_fetch = 3'd5;
   localparam logic [2:0] c_s_stream     = 3'd6;

   logic [2:0]            r_state;
   logic [2:0]            w_next;

   logic [ADDR_WIDTH-1:0] r_line_addr;
   logic [c_ow-1:0]       r_offset;
   logic [c_lw:0]         r_remaining;
   logic [c_tw-1:0]       r_tag;
   logic                  r_miss;
   logic [1:0]            r_miss_st;
   logic [15:0]           r_miss_cnt;
   logic [1:0]            r_fetch_cmd;
   logic [c_tw-1:0]       r_fetch_tag;
   logic [ADDR_WIDTH-1:0] r_fetch_addr;
   logic [ADDR_WIDTH-1:0] r_fetch_victim;

   logic                  r_lq [FIFO_DEPTH];
   logic [c_pw-1:0]       r_lq_wp;
   logic [c_pw-1:0]       r_lq_rp;
   logic [c_cw-1:0]       r_inflight;

   logic [DATA_WIDTH:0]   r_fd [FIFO_DEPTH];
   logic [c_pw-1:0]       r_fd_wp;
   logic [c_pw-1:0]       r_fd_rp;
   logic [c_cw-1:0]       r_fifo_cnt;

   logic                  w_req_fire;
   logic                  w_hit;
   logic [ADDR_WIDTH-1:0] w_req_line;
   logic [c_ow-1:0]       w_req_off;
   logic                  w_conflict;
   logic                  w_alloc;
   logic                  w_credit_ok;
   logic                  w_issue;
   logic                  w_fire;
   logic                  w_last_fire;
   logic                  w_ret;
   logic                  w_pop;

   assign w_req_fire  = req_valid && (r_state == c_s_idle);
   assign w_hit       = (dir_status == 3'b001) || (dir_status == 3'b010);
   assign w_req_line  = (req_addr >> c_loff) << c_loff;
   assign w_req_off   = req_addr[c_loff-1:c_boff];
   assign w_conflict  = ((wr_status == 3'b001) || (wr_status == 3'b010)) && (wr_addr == r_line_addr);
   assign w_alloc     = (r_state == c_s_allocate) && !alloc_busy;

   // Credit counts both queued responses and reads still in flight, so the FIFO can never overflow.
   assign w_credit_ok = ({1'b0, r_fifo_cnt} + {1'b0, r_inflight}) < c_credit;
   assign w_issue     = (r_state == c_s_stream) && (r_remaining != '0) && w_credit_ok;
   assign w_fire      = w_issue && mem_rready;
   assign w_last_fire = w_fire && (r_remaining == (c_lw + 1)'(1));
   assign w_ret       = mem_rdata_valid && (r_inflight != '0);
   assign w_pop       = (r_fifo_cnt != '0) && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_s_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_s_idle:       if (req_valid) w_next = w_hit ? c_s_stream : c_s_check;
         c_s_check:      w_next = w_conflict ? c_s_wait_conf : c_s_allocate;
         c_s_wait_conf:  if (wr_status == 3'b011) w_next = c_s_stream;
         c_s_allocate:   if (!alloc_busy) w_next = c_s_fetch_req;
         c_s_fetch_req:  if (fetch_gnt) w_next = c_s_wait_fetch;
         c_s_wait_fetch: if (fetch_done) w_next = c_s_stream;
         c_s_stream:     if (w_last_fire) w_next = c_s_idle;
         default:        w_next = c_s_idle;
      endcase
   end

   always_comb begin
      req_ready   = (r_state == c_s_idle);
      dir_req     = 1'b0;
      dir_cmd     = 2'b00;
      dir_index   = '0;
      dir_upd_tag = '0;
      rd_status   = 3'b000;
      fetch_req   = 1'b0;
      mem_ren     = w_issue;
      case (r_state)
         c_s_idle: begin
            if (req_valid) begin
               dir_req   = 1'b1;
               dir_index = w_req_line;
            end
         end
         c_s_check: rd_status = 3'b001;
         c_s_allocate: begin
            rd_status = 3'b010;
            if (!alloc_busy) begin
               dir_req   = 1'b1;
               dir_cmd   = 2'b10;
               dir_index = r_line_addr;
            end
         end
         c_s_fetch_req: begin
            rd_status = 3'b010;
            fetch_req = 1'b1;
         end
         c_s_wait_fetch: rd_status = 3'b010;
         c_s_stream: begin
            if (r_miss) rd_status = w_last_fire ? 3'b011 : 3'b010;
            if (w_last_fire) begin
               dir_req     = 1'b1;
               dir_cmd     = 2'b11;
               dir_index   = r_line_addr;
               dir_upd_tag = r_tag;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_addr    <= '0;
         r_offset       <= '0;
         r_remaining    <= '0;
         r_tag          <= '0;
         r_miss         <= 1'b0;
         r_miss_st      <= 2'b00;
         r_miss_cnt     <= 16'd0;
         r_fetch_cmd    <= 2'b00;
         r_fetch_tag    <= '0;
         r_fetch_addr   <= '0;
         r_fetch_victim <= '0;
      end else begin
         if (w_req_fire) begin
            r_line_addr <= w_req_line;
            r_offset    <= w_req_off;
            r_remaining <= {1'b0, req_len} + (c_lw + 1)'(1);
            r_tag       <= dir_tag;
            r_miss      <= !w_hit;
            r_miss_st   <= dir_status[1:0];
            if (!w_hit && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
         end
         if ((r_state == c_s_wait_conf) && (wr_status == 3'b011)) r_tag <= wr_tag;
         if (w_alloc) begin
            r_tag          <= dir_tag;
            r_fetch_tag    <= dir_tag;
            r_fetch_addr   <= r_line_addr;
            r_fetch_victim <= dir_victim;
            r_fetch_cmd    <= r_miss_st;
         end
         if (w_fire) begin
            r_offset    <= (r_offset == c_last_off) ? '0 : r_offset + c_ow'(1);
            r_remaining <= r_remaining - (c_lw + 1)'(1);
         end
      end
   end

   // Last-bit queue mirrors in-flight reads; its occupancy is the in-flight count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_lq[i] <= 1'b0;
         r_lq_wp    <= '0;
         r_lq_rp    <= '0;
         r_inflight <= '0;
      end else begin
         if (w_fire) begin
            r_lq[r_lq_wp] <= w_last_fire;
            r_lq_wp       <= r_lq_wp + c_pw'(1);
         end
         if (w_ret) r_lq_rp <= r_lq_rp + c_pw'(1);
         case ({w_fire, w_ret})
            2'b10:   r_inflight <= r_inflight + c_cw'(1);
            2'b01:   r_inflight <= r_inflight - c_cw'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_fd[i] <= '0;
         r_fd_wp    <= '0;
         r_fd_rp    <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_ret) begin
            r_fd[r_fd_wp] <= {mem_rdata, r_lq[r_lq_rp]};
            r_fd_wp       <= r_fd_wp + c_pw'(1);
         end
         if (w_pop) r_fd_rp <= r_fd_rp + c_pw'(1);
         case ({w_ret, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + c_cw'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - c_cw'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   assign rsp_valid    = (r_fifo_cnt != '0);
   assign rsp_data     = r_fd[r_fd_rp][DATA_WIDTH:1];
   assign rsp_last     = r_fd[r_fd_rp][0];
   assign rd_addr      = r_line_addr;
   assign rd_tag       = r_tag;
   assign fetch_cmd    = r_fetch_cmd;
   assign fetch_tag    = r_fetch_tag;
   assign fetch_addr   = r_fetch_addr;
   assign fetch_victim = r_fetch_victim;
   assign mem_raddr    = w_issue ? {r_tag, r_offset} : '0;
   assign miss_cnt     = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rd_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_rd_burst_ctrl                                                  |
// | Directed self-checking bench for rd_burst_ctrl with default parameters.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rd_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_len = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        dir_req;
   logic [1:0]  dir_cmd;
   logic [31:0] dir_index;
   logic [2:0]  dir_status = '0;
   logic [1:0]  dir_tag = '0;
   logic [31:0] dir_victim = '0;
   logic        alloc_busy = 1'b0;
   logic [1:0]  dir_upd_tag;
   logic [2:0]  rd_status;
   logic [31:0] rd_addr;
   logic [1:0]  rd_tag;
   logic [2:0]  wr_status = '0;
   logic [31:0] wr_addr = '0;
   logic [1:0]  wr_tag = '0;
   logic        fetch_req;
   logic        fetch_gnt = 1'b0;
   logic        fetch_done = 1'b0;
   logic [1:0]  fetch_cmd;
   logic [1:0]  fetch_tag;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_victim;
   logic        mem_ren;
   logic        mem_rready = 1'b1;
   logic [6:0]  mem_raddr;
   logic [31:0] mem_rdata = '0;
   logic        mem_rdata_valid = 1'b0;
   logic [15:0] miss_cnt;

   int checks = 0;
   int errors = 0;

   int n_touch = 0, n_alloc = 0, n_s011 = 0, n_snz = 0, n_freq = 0;
   logic [1:0]  last_touch_tag = '0;
   logic [6:0]  iss_q[$];
   logic [31:0] rsp_d_q[$];
   logic        rsp_l_q[$];
   logic        pend_v = 1'b0;
   logic [31:0] pend_d = '0;

   always #5 clk = ~clk;

   rd_burst_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .dir_req(dir_req), .dir_cmd(dir_cmd), .dir_index(dir_index), .dir_status(dir_status),
      .dir_tag(dir_tag), .dir_victim(dir_victim), .alloc_busy(alloc_busy), .dir_upd_tag(dir_upd_tag),
      .rd_status(rd_status), .rd_addr(rd_addr), .rd_tag(rd_tag),
      .wr_status(wr_status), .wr_addr(wr_addr), .wr_tag(wr_tag),
      .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done), .fetch_cmd(fetch_cmd),
      .fetch_tag(fetch_tag), .fetch_addr(fetch_addr), .fetch_victim(fetch_victim),
      .mem_ren(mem_ren), .mem_rready(mem_rready), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .miss_cnt(miss_cnt)
   );

   // Data RAM with one-cycle read latency (word = C0DE0000 | raddr) plus event monitor.
   always @(negedge clk) begin
      mem_rdata_valid = pend_v;
      mem_rdata       = pend_v ? pend_d : 32'h0;
      pend_v          = rst_n && mem_ren && mem_rready;
      pend_d          = 32'hC0DE0000 | {25'd0, mem_raddr};
      if (rst_n) begin
         if (mem_ren && mem_rready) iss_q.push_back(mem_raddr);
         if (rsp_valid && rsp_ready) begin
            rsp_d_q.push_back(rsp_data);
            rsp_l_q.push_back(rsp_last);
         end
         if (dir_req && dir_cmd == 2'b11) begin
            n_touch++;
            last_touch_tag = dir_upd_tag;
         end
         if (dir_req && dir_cmd == 2'b10) n_alloc++;
         if (rd_status == 3'b011) n_s011++;
         if (rd_status != 3'b000) n_snz++;
         if (fetch_req) n_freq++;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      step;
      #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dir_req !== 1'b0 || fetch_req !== 1'b0 || mem_ren !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: ready=%b rsp_valid=%b dir_req=%b fetch_req=%b mem_ren=%b, required 1 0 0 0 0",
                  req_ready, rsp_valid, dir_req, fetch_req, mem_ren);
      end
      checks++;
      if (fetch_cmd !== 2'b00 || rd_status !== 3'b000 || miss_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_regs: fetch_cmd=%b rd_status=%b miss_cnt=%0d, required 00 000 0", fetch_cmd, rd_status, miss_cnt);
      end
      rst_n = 1'b1;
      step;
   endtask

   task automatic test_hit;
      int i0, r0, s0, t0;
      logic [6:0] exp_a [4] = '{7'h21, 7'h22, 7'h23, 7'h24};
      i0 = iss_q.size(); r0 = rsp_d_q.size(); s0 = n_snz; t0 = n_touch;
      req_valid = 1'b1; req_addr = 32'h104; req_len = 3'd3; dir_status = 3'b001; dir_tag = 2'd1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || dir_req !== 1'b1 || dir_cmd !== 2'b00 || dir_index !== 32'h100) begin
         errors++;
         $display("FAIL hit_lookup: ready=%b dir_req=%b cmd=%b index=%h, required 1 1 00 00000100", req_ready, dir_req, dir_cmd, dir_index);
      end
      step;
      req_valid = 1'b0; dir_status = 3'b000; dir_tag = 2'd0;
      checks++;
      if (mem_ren !== 1'b1 || mem_raddr !== 7'h21) begin
         errors++;
         $display("FAIL hit_first_issue: mem_ren=%b raddr=%h, required 1 21", mem_ren, mem_raddr);
      end
      step;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL hit_rsp_early: rsp_valid=%b, required 0", rsp_valid);
      end
      step;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hC0DE0021) begin
         errors++;
         $display("FAIL hit_rsp_latency: rsp_valid=%b data=%h, required 1 c0de0021", rsp_valid, rsp_data);
      end
      step;
      #1;
      checks++;
      if (dir_req !== 1'b1 || dir_cmd !== 2'b11 || dir_upd_tag !== 2'd1 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL hit_touch: dir_req=%b cmd=%b upd_tag=%0d ready=%b, required 1 11 1 0", dir_req, dir_cmd, dir_upd_tag, req_ready);
      end
      step;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL hit_idle_ready: ready=%b, required 1", req_ready);
      end
      for (int k = 0; k < 40 && rsp_d_q.size() < r0 + 4; k++) step;
      checks++;
      if (iss_q.size() - i0 != 4 || rsp_d_q.size() - r0 != 4) begin
         errors++;
         $display("FAIL hit_counts: issues=%0d rsps=%0d, required 4 4", iss_q.size() - i0, rsp_d_q.size() - r0);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (i0 + k >= iss_q.size() || r0 + k >= rsp_d_q.size() || iss_q[i0+k] !== exp_a[k] ||
             rsp_d_q[r0+k] !== (32'hC0DE0000 | {25'd0, exp_a[k]}) || rsp_l_q[r0+k] !== (k == 3)) begin
            errors++;
            $display("FAIL hit_beat%0d: raddr/data/last wrong, required raddr %h last %0d", k, exp_a[k], (k == 3));
         end
      end
      checks++;
      if (n_snz != s0 || n_touch - t0 != 1 || last_touch_tag !== 2'd1) begin
         errors++;
         $display("FAIL hit_status: nonzero rd_status cycles=%0d touches=%0d tag=%0d, required 0 1 1", n_snz - s0, n_touch - t0, last_touch_tag);
      end
   endtask

   task automatic test_wrap;
      int i0, r0;
      logic [6:0] exp_a [4] = '{7'h3E, 7'h3F, 7'h20, 7'h21};
      i0 = iss_q.size(); r0 = rsp_d_q.size();
      req_valid = 1'b1; req_addr = 32'h178; req_len = 3'd3; dir_status = 3'b010; dir_tag = 2'd1;
      step;
      req_valid = 1'b0; dir_status = 3'b000; dir_tag = 2'd0;
      for (int k = 0; k < 40 && rsp_d_q.size() < r0 + 4; k++) step;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (i0 + k >= iss_q.size() || r0 + k >= rsp_d_q.size() || iss_q[i0+k] !== exp_a[k] ||
             rsp_d_q[r0+k] !== (32'hC0DE0000 | {25'd0, exp_a[k]}) || rsp_l_q[r0+k] !== (k == 3)) begin
            errors++;
            $display("FAIL wrap_beat%0d: raddr/data/last wrong, required raddr %h last %0d", k, exp_a[k], (k == 3));
         end
      end
   endtask

   task automatic test_miss;
      int r0, a0, s0;
      r0 = rsp_d_q.size(); a0 = n_alloc; s0 = n_s011;
      step;
      req_valid = 1'b1; req_addr = 32'h204; req_len = 3'd1; dir_status = 3'b100; dir_tag = 2'd0; alloc_busy = 1'b1;
      step;
      req_valid = 1'b0; dir_status = 3'b000;
      checks++;
      if (rd_status !== 3'b001 || rd_addr !== 32'h200) begin
         errors++;
         $display("FAIL miss_check: rd_status=%b rd_addr=%h, required 001 00000200", rd_status, rd_addr);
      end
      for (int k = 0; k < 3; k++) begin
         step;
         checks++;
         if (rd_status !== 3'b010 || dir_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_alloc_busy%0d: rd_status=%b dir_req=%b, required 010 0", k, rd_status, dir_req);
         end
      end
      step;
      alloc_busy = 1'b0; dir_tag = 2'd3; dir_victim = 32'h380;
      #1;
      checks++;
      if (dir_req !== 1'b1 || dir_cmd !== 2'b10 || dir_index !== 32'h200) begin
         errors++;
         $display("FAIL miss_alloc: dir_req=%b cmd=%b index=%h, required 1 10 00000200", dir_req, dir_cmd, dir_index);
      end
      step;
      dir_tag = 2'd0; dir_victim = 32'h0;
      checks++;
      if (fetch_req !== 1'b1 || fetch_cmd !== 2'b00 || fetch_tag !== 2'd3 || fetch_addr !== 32'h200 || fetch_victim !== 32'h380) begin
         errors++;
         $display("FAIL miss_fetch: req=%b cmd=%b tag=%0d addr=%h victim=%h, required 1 00 3 00000200 00000380",
                  fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_victim);
      end
      step;
      fetch_gnt = 1'b1;
      step;
      fetch_gnt = 1'b0;
      checks++;
      if (fetch_req !== 1'b0 || rd_status !== 3'b010 || mem_ren !== 1'b0) begin
         errors++;
         $display("FAIL miss_wait_fetch: fetch_req=%b rd_status=%b mem_ren=%b, required 0 010 0", fetch_req, rd_status, mem_ren);
      end
      step;
      fetch_done = 1'b1;
      step;
      fetch_done = 1'b0;
      #1;
      checks++;
      if (mem_ren !== 1'b1 || mem_raddr !== 7'h61 || rd_status !== 3'b010) begin
         errors++;
         $display("FAIL miss_stream0: mem_ren=%b raddr=%h rd_status=%b, required 1 61 010", mem_ren, mem_raddr, rd_status);
      end
      step;
      #1;
      checks++;
      if (mem_raddr !== 7'h62 || rd_status !== 3'b011 || dir_cmd !== 2'b11 || dir_upd_tag !== 2'd3) begin
         errors++;
         $display("FAIL miss_stream1: raddr=%h rd_status=%b cmd=%b upd_tag=%0d, required 62 011 11 3", mem_raddr, rd_status, dir_cmd, dir_upd_tag);
      end
      for (int k = 0; k < 40 && rsp_d_q.size() < r0 + 2; k++) step;
      checks++;
      if (n_alloc - a0 != 1 || n_s011 - s0 != 1 || miss_cnt !== 16'd1 || rsp_d_q.size() - r0 != 2 || fetch_tag !== 2'd3) begin
         errors++;
         $display("FAIL miss_summary: allocs=%0d pulses011=%0d miss_cnt=%0d rsps=%0d fetch_tag=%0d, required 1 1 1 2 3",
                  n_alloc - a0, n_s011 - s0, miss_cnt, rsp_d_q.size() - r0, fetch_tag);
      end
   endtask

   task automatic test_conflict;
      int i0, a0, f0;
      i0 = iss_q.size(); a0 = n_alloc; f0 = n_freq;
      step;
      req_valid = 1'b1; req_addr = 32'h300; req_len = 3'd1; dir_status = 3'b000; dir_tag = 2'd0;
      wr_status = 3'b010; wr_addr = 32'h300;
      step;
      req_valid = 1'b0;
      checks++;
      if (rd_status !== 3'b001) begin
         errors++;
         $display("FAIL conf_check: rd_status=%b, required 001", rd_status);
      end
      step;
      step;
      checks++;
      if (mem_ren !== 1'b0 || dir_req !== 1'b0 || fetch_req !== 1'b0) begin
         errors++;
         $display("FAIL conf_wait: mem_ren=%b dir_req=%b fetch_req=%b, required 0 0 0", mem_ren, dir_req, fetch_req);
      end
      wr_status = 3'b011; wr_tag = 2'd2;
      step;
      wr_status = 3'b000; wr_tag = 2'd0; wr_addr = 32'h0;
      checks++;
      if (mem_ren !== 1'b1 || mem_raddr !== 7'h40 || rd_tag !== 2'd2) begin
         errors++;
         $display("FAIL conf_stream: mem_ren=%b raddr=%h rd_tag=%0d, required 1 40 2", mem_ren, mem_raddr, rd_tag);
      end
      for (int k = 0; k < 20; k++) step;
      checks++;
      if (iss_q.size() - i0 != 2 || (iss_q.size() >= i0 + 2 && iss_q[i0+1] !== 7'h41) || n_alloc != a0 || n_freq != f0 || miss_cnt !== 16'd2) begin
         errors++;
         $display("FAIL conf_summary: issues=%0d allocs=%0d fetch_req_cycles=%0d miss_cnt=%0d, required 2 0 0 2",
                  iss_q.size() - i0, n_alloc - a0, n_freq - f0, miss_cnt);
      end
   endtask

   task automatic test_backpressure;
      int i0, r0;
      i0 = iss_q.size(); r0 = rsp_d_q.size();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0; req_len = 3'd7; dir_status = 3'b001; dir_tag = 2'd0;
      step;
      req_valid = 1'b0; dir_status = 3'b000;
      for (int k = 0; k < 20; k++) step;
      checks++;
      if (iss_q.size() - i0 != 4 || mem_ren !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'hC0DE0000) begin
         errors++;
         $display("FAIL bp_stall: issues=%0d mem_ren=%b rsp_valid=%b data=%h, required 4 0 1 c0de0000",
                  iss_q.size() - i0, mem_ren, rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 60 && rsp_d_q.size() < r0 + 8; k++) step;
      checks++;
      if (rsp_d_q.size() - r0 != 8) begin
         errors++;
         $display("FAIL bp_count: rsps=%0d, required 8", rsp_d_q.size() - r0);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (r0 + k >= rsp_d_q.size() || rsp_d_q[r0+k] !== (32'hC0DE0000 + k) || rsp_l_q[r0+k] !== (k == 7)) begin
            errors++;
            $display("FAIL bp_beat%0d: data/last wrong, required %h last %0d", k, 32'hC0DE0000 + k, (k == 7));
         end
      end
   endtask

   task automatic test_reset_mid;
      int i0, r0;
      i0 = iss_q.size();
      req_valid = 1'b1; req_addr = 32'h0; req_len = 3'd7; dir_status = 3'b001; dir_tag = 2'd1;
      step;
      req_valid = 1'b0; dir_status = 3'b000; dir_tag = 2'd0;
      step;
      step;
      rst_n = 1'b0;
      #1;
      checks++;
      if (iss_q.size() - i0 != 2 || req_ready !== 1'b1 || mem_ren !== 1'b0 || rsp_valid !== 1'b0 ||
          rd_status !== 3'b000 || miss_cnt !== 16'd0 || dir_req !== 1'b0 || fetch_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: issued=%0d ready=%b mem_ren=%b rsp_valid=%b rd_status=%b miss_cnt=%0d, required 2 1 0 0 000 0",
                  iss_q.size() - i0, req_ready, mem_ren, rsp_valid, rd_status, miss_cnt);
      end
      step;
      rst_n = 1'b1;
      step;
      i0 = iss_q.size(); r0 = rsp_d_q.size();
      req_valid = 1'b1; req_addr = 32'h104; req_len = 3'd1; dir_status = 3'b001; dir_tag = 2'd2;
      step;
      req_valid = 1'b0; dir_status = 3'b000; dir_tag = 2'd0;
      for (int k = 0; k < 20; k++) step;
      checks++;
      if (iss_q.size() - i0 != 2 || rsp_d_q.size() - r0 != 2 ||
          (rsp_d_q.size() >= r0 + 2 && (rsp_d_q[r0] !== 32'hC0DE0041 || rsp_d_q[r0+1] !== 32'hC0DE0042 || rsp_l_q[r0+1] !== 1'b1))) begin
         errors++;
         $display("FAIL rst_recover: issues=%0d rsps=%0d, required 2 2 with data c0de0041 c0de0042", iss_q.size() - i0, rsp_d_q.size() - r0);
      end
   endtask

   initial begin
      test_reset;
      test_hit;
      test_wrap;
      test_miss;
      test_conflict;
      test_backpressure;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
